// File: rtl/spm_program_loader.sv
// Byte-stream program loader for the RISC SPM core: unpacks ADDR/LEN/DATA/CSUM frames
// into external memory writes and holds the core in reset until a good checksum.
module spm_program_loader #(
  parameter int word_size = 8,
  parameter int len_size  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_req,
  input  logic [word_size-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 ext_write,
  output logic [word_size-1:0] address_bus,
  output logic [word_size-1:0] data_bus,
  output logic                 cpu_rst,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  // state   | meaning
  // S_IDLE  | no download; cpu_rst reflects last outcome
  // S_ADDR  | waiting for start address byte
  // S_LEN   | waiting for word count byte (0 = 256)
  // S_DATA  | waiting for next data byte
  // S_WRITE | strobing ext_write for the captured word
  // S_CSUM  | waiting for checksum byte
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_LEN   = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_CSUM  = 3'd5;

  localparam logic [len_size:0] REM_ONE = (len_size + 1)'(1);
  localparam logic [len_size:0] REM_MAX = {1'b1, {len_size{1'b0}}};

  logic [2:0]           state_q, state_d;
  logic [word_size-1:0] addr_q, addr_d;
  logic [word_size-1:0] data_q, data_d;
  logic [word_size-1:0] csum_q, csum_d;
  logic [len_size:0]    rem_q, rem_d;
  logic                 ext_write_q, ext_write_d;
  logic                 cpu_rst_q, cpu_rst_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 xfer;

  assign in_ready = (state_q == S_ADDR) || (state_q == S_LEN) ||
                    (state_q == S_DATA) || (state_q == S_CSUM);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    csum_d      = csum_q;
    rem_d       = rem_q;
    ext_write_d = 1'b0;
    cpu_rst_d   = cpu_rst_q;
    done_d      = done_q;
    err_d       = err_q;
    // A restart wins over any byte offered in the same cycle.
    if (load_req) begin
      state_d   = S_ADDR;
      csum_d    = '0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      cpu_rst_d = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: if (xfer) begin
          addr_d  = in_data;
          state_d = S_LEN;
        end
        S_LEN: if (xfer) begin
          rem_d   = (in_data[len_size-1:0] == '0) ? REM_MAX : {1'b0, in_data[len_size-1:0]};
          state_d = S_DATA;
        end
        S_DATA: if (xfer) begin
          data_d      = in_data;
          csum_d      = csum_q ^ in_data;
          ext_write_d = 1'b1;
          state_d     = S_WRITE;
        end
        S_WRITE: begin
          addr_d  = addr_q + word_size'(1);
          rem_d   = rem_q - REM_ONE;
          state_d = (rem_q == REM_ONE) ? S_CSUM : S_DATA;
        end
        S_CSUM: if (xfer) begin
          state_d = S_IDLE;
          if (in_data == csum_q) begin
            done_d    = 1'b1;
            cpu_rst_d = 1'b1;
          end else begin
            err_d     = 1'b1;
            cpu_rst_d = 1'b0;
          end
        end
        S_IDLE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      csum_q      <= '0;
      rem_q       <= '0;
      ext_write_q <= 1'b0;
      cpu_rst_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      csum_q      <= csum_d;
      rem_q       <= rem_d;
      ext_write_q <= ext_write_d;
      cpu_rst_q   <= cpu_rst_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign ext_write   = ext_write_q;
  assign address_bus = addr_q;
  assign data_bus    = data_q;
  assign cpu_rst     = cpu_rst_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_spm_program_loader.sv
// Scoreboard bench for spm_program_loader: expected writes are queued as data bytes
// are driven and matched against every ext_write strobe.
module tb_spm_program_loader;

  typedef logic [7:0] bq_t[$];
  typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;

  logic       clk = 1'b0;
  logic       rst, load_req, in_valid;
  logic [7:0] in_data;
  logic       in_ready, ext_write, cpu_rst, busy, done, err;
  logic [7:0] address_bus, data_bus;

  int     tests_run = 0;
  int     tests_failed = 0;
  wr_t    exp_q[$];
  wr_t    e;
  logic [7:0] mem [256];
  logic [7:0] exp_mem [256];
  bit     cov [256];
  int     wr_count = 0;
  longint cyc = 0;
  longint last_wr = 0, prev_wr = 0;

  spm_program_loader #(.word_size(8), .len_size(8)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ext_write(ext_write), .address_bus(address_bus),
    .data_bus(data_bus), .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ext_write === 1'b1) mem[address_bus] <= data_bus;
  end

  // Every strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (ext_write === 1'b1) begin
      wr_count++;
      cov[address_bus] = 1'b1;
      prev_wr = last_wr;
      last_wr = cyc;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", address_bus, data_bus);
      end else begin
        e = exp_q.pop_front();
        if ({address_bus, data_bus} !== {e.a, e.d}) begin
          tests_failed++;
          $display("FAIL write_match: got addr=%h data=%h, required addr=%h data=%h",
                   address_bus, data_bus, e.a, e.d);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    if (!in_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, t);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic pulse_load();
    @(negedge clk);
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input int n, input bq_t d,
                            input logic [7:0] adj, input int maxgap);
    logic [7:0] cs, wa, nb;
    cs = 8'h00;
    wa = a;
    nb = n[7:0];
    send_byte(a, maxgap == 0 ? 0 : $urandom_range(maxgap, 0));
    send_byte(nb, maxgap == 0 ? 0 : $urandom_range(maxgap, 0));
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{a: wa, d: d[i]});
      exp_mem[wa] = d[i];
      cs = cs ^ d[i];
      send_byte(d[i], maxgap == 0 ? 0 : $urandom_range(maxgap, 0));
      tests_run++;
      if (ext_write !== 1'b1) begin
        tests_failed++;
        $display("FAIL write_latency: ext_write=%b one cycle after data byte %0d, required 1", ext_write, i);
      end
      wa = wa + 8'd1;
    end
    send_byte(cs ^ adj, maxgap == 0 ? 0 : $urandom_range(maxgap, 0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load_req = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if ({in_ready, ext_write, busy, done, err, cpu_rst} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got rdy/wr/busy/done/err/cpu_rst=%b, required 000000",
               {in_ready, ext_write, busy, done, err, cpu_rst});
    end
    tests_run++;
    if ({address_bus, data_bus} !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_buses: got addr=%h data=%h, required 00 00", address_bus, data_bus);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    tests_run++;
    if ({in_ready, busy, cpu_rst, done, err} !== 5'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got rdy/busy/cpu_rst/done/err=%b, required 00000",
               {in_ready, busy, cpu_rst, done, err});
    end
  endtask

  task automatic test_basic();
    bq_t d;
    d = {8'hA1, 8'hB2, 8'hC3};
    pulse_load();
    tests_run++;
    if ({busy, in_ready, cpu_rst} !== 3'b110) begin
      tests_failed++;
      $display("FAIL load_state: got busy/rdy/cpu_rst=%b, required 110", {busy, in_ready, cpu_rst});
    end
    send_frame(8'h10, 3, d, 8'h00, 0);
    tests_run++;
    if ({done, err, cpu_rst, busy} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL basic_done: got done/err/cpu_rst/busy=%b, required 1010", {done, err, cpu_rst, busy});
    end
    tests_run++;
    if (last_wr - prev_wr != 2) begin
      tests_failed++;
      $display("FAIL throughput: got write spacing %0d cycles, required 2", last_wr - prev_wr);
    end
    tests_run++;
    if ({mem[8'h10], mem[8'h11], mem[8'h12]} !== 24'hA1B2C3) begin
      tests_failed++;
      $display("FAIL readback: got %h %h %h, required a1 b2 c3", mem[8'h10], mem[8'h11], mem[8'h12]);
    end
  endtask

  task automatic test_wrap();
    bq_t d;
    d = {8'h5A, 8'h3C, 8'h99};
    for (int i = 0; i < 256; i++) cov[i] = 1'b0;
    pulse_load();
    send_frame(8'hFE, 3, d, 8'h00, 2);
    tests_run++;
    if ({cov[8'hFE], cov[8'hFF], cov[8'h00], done} !== 4'b1111) begin
      tests_failed++;
      $display("FAIL wrap: got cov fe/ff/00 and done=%b, required 1111",
               {cov[8'hFE], cov[8'hFF], cov[8'h00], done});
    end
    tests_run++;
    if ({mem[8'hFE], mem[8'hFF], mem[8'h00]} !== 24'h5A3C99) begin
      tests_failed++;
      $display("FAIL wrap_readback: got %h %h %h, required 5a 3c 99", mem[8'hFE], mem[8'hFF], mem[8'h00]);
    end
  endtask

  task automatic test_bad_csum();
    bq_t d;
    d = {8'h01, 8'h22, 8'h47, 8'h80};
    pulse_load();
    send_frame(8'h30, 4, d, 8'h01, 1);
    tests_run++;
    if ({err, done, cpu_rst, busy} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL bad_csum: got err/done/cpu_rst/busy=%b, required 1000", {err, done, cpu_rst, busy});
    end
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if ({err, cpu_rst} !== 2'b10) begin
      tests_failed++;
      $display("FAIL err_sticky: got err/cpu_rst=%b, required 10", {err, cpu_rst});
    end
    pulse_load();
    send_frame(8'h30, 4, d, 8'h00, 0);
    tests_run++;
    if ({done, err, cpu_rst} !== 3'b101) begin
      tests_failed++;
      $display("FAIL reload_good: got done/err/cpu_rst=%b, required 101", {done, err, cpu_rst});
    end
  endtask

  task automatic test_len0();
    bq_t d;
    int covered;
    for (int i = 0; i < 256; i++) begin
      cov[i] = 1'b0;
      d.push_back(8'($urandom_range(255, 0)));
    end
    wr_count = 0;
    pulse_load();
    send_frame(8'($urandom_range(255, 0)), 256, d, 8'h00, 0);
    covered = 0;
    for (int i = 0; i < 256; i++) if (cov[i]) covered++;
    tests_run++;
    if (wr_count != 256 || covered != 256) begin
      tests_failed++;
      $display("FAIL len0_count: got %0d writes covering %0d addresses, required 256/256", wr_count, covered);
    end
    tests_run++;
    if ({done, err, cpu_rst} !== 3'b101) begin
      tests_failed++;
      $display("FAIL len0_done: got done/err/cpu_rst=%b, required 101", {done, err, cpu_rst});
    end
  endtask

  task automatic test_abort();
    bq_t d;
    int t;
    d = {8'h0F, 8'hF0};
    pulse_load();
    send_byte(8'h40, 0);
    send_byte(8'd5, 0);
    exp_q.push_back('{a: 8'h40, d: 8'h11});
    send_byte(8'h11, 0);
    exp_q.push_back('{a: 8'h41, d: 8'h22});
    send_byte(8'h22, 0);
    tests_run++;
    if (cpu_rst !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_cpu_rst_mid: got cpu_rst=%b, required 0", cpu_rst);
    end
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 10) begin @(negedge clk); t++; end
    load_req = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    @(posedge clk);
    #1 load_req = 1'b0;
    in_valid = 1'b0;
    tests_run++;
    if ({busy, in_ready, cpu_rst, done} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL abort_state: got busy/rdy/cpu_rst/done=%b, required 1100", {busy, in_ready, cpu_rst, done});
    end
    send_frame(8'h80, 2, d, 8'h00, 0);
    tests_run++;
    if ({done, err, cpu_rst, address_bus} !== {3'b101, 8'h82}) begin
      tests_failed++;
      $display("FAIL abort_reload: got done/err/cpu_rst=%b addr=%h, required 101 addr=82",
               {done, err, cpu_rst}, address_bus);
    end
  endtask

  task automatic test_rst_mid_write();
    int wc;
    pulse_load();
    send_byte(8'h20, $urandom_range(3, 0));
    send_byte(8'd4, $urandom_range(3, 0));
    exp_q.push_back('{a: 8'h20, d: 8'hAB});
    send_byte(8'hAB, $urandom_range(3, 0));
    exp_q.push_back('{a: 8'h21, d: 8'hCD});
    send_byte(8'hCD, $urandom_range(3, 0));
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    tests_run++;
    if ({ext_write, in_ready, busy, cpu_rst, done, err} !== 6'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_flags: got wr/rdy/busy/cpu_rst/done/err=%b, required 000000",
               {ext_write, in_ready, busy, cpu_rst, done, err});
    end
    tests_run++;
    if ({address_bus, data_bus} !== 16'h0000) begin
      tests_failed++;
      $display("FAIL rst_mid_buses: got addr=%h data=%h, required 00 00", address_bus, data_bus);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL rst_mid_pending: got %0d pending writes, required 0", exp_q.size());
      exp_q.delete();
    end
    wc = wr_count;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(1, 0));
      in_data  = 8'($urandom_range(255, 0));
    end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'($urandom_range(255, 0));
    end
    in_valid = 1'b0;
    tests_run++;
    if (wr_count != wc || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_no_writes: got %0d extra writes busy=%b, required 0 busy=0", wr_count - wc, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_bad_csum();
    test_len0();
    test_abort();
    test_rst_mid_write();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL final_queue: got %0d unmatched writes, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
